acc_activation_drain: RTL and testbench
=======================================

Name: acc_activation_drain

Overview:
- Drains finished result rows from the 128x32 accumulator store and applies activation and requantization to each element: optional ReLU, then scale, rounding shift and saturation to int8.
- Emits packed int8 rows to the unified-buffer writer over a valid/ready stream.
- Sits directly downstream of the accumulator and drives its read port: read enable, read address, NORMAL read mode with add disabled.
- A 3-stage pipeline plus an output FIFO, credit-gated, absorbs writer backpressure.

Parameters:
- N_COLS, 32, elements per accumulator row.
- ACC_W, 32, accumulator element width (signed).
- OUT_W, 8, output element width (signed).
- ADDR_W, 7, accumulator row address width.
- FIFO_DEPTH, 4, output FIFO entries; power of two, at least 2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  start-drain pulse; sampled only in IDLE.
- base_addr_i  in  ADDR_W  first accumulator row; latched at start.
- num_rows_i  in  ADDR_W+1  rows to drain, 0..128; latched at start.
- relu_en_i  in  1  enable ReLU; latched at start.
- scale_i  in  16  unsigned multiplier; latched at start.
- shift_i  in  5  right-shift amount, 0..31; latched at start.
- acc_rd_en_o  out  1  accumulator read enable.
- acc_addr_o  out  ADDR_W  accumulator read address.
- acc_data_i  in  N_COLS x ACC_W  accumulator read data; valid in the same cycle as acc_rd_en_o.
- out_valid_o  out  1  output row valid.
- out_ready_i  in  1  writer ready.
- out_data_o  out  N_COLS x OUT_W  packed int8 row; element 0 is the low byte.
- out_row_o  out  ADDR_W  row index relative to base, 0..num_rows-1.
- busy_o  out  1  high from start acceptance until done.
- done_o  out  1  one-cycle pulse when the last row is accepted downstream.

Behaviour:
- Reset (asynchronous):
  - FSM goes to IDLE; FIFO and pipeline valids are cleared.
  - All outputs are 0, including out_data_o and acc_addr_o.
  - Reset mid-drain abandons the drain; no done pulse is generated.
- FSM states: IDLE, ISSUE, FLUSH, DONE.
  - IDLE to ISSUE: start_i=1 and num_rows_i!=0. Operands are latched and busy_o rises the next cycle.
  - IDLE to DONE: start_i=1 and num_rows_i=0. No reads are issued; done_o pulses 1 cycle after start.
  - ISSUE to FLUSH: the last read has been issued.
  - FLUSH to DONE: pipeline empty, FIFO empty and the last handshake done.
  - DONE to IDLE: unconditional. done_o=1 and busy_o=0 in the DONE cycle.
  - start_i outside IDLE is ignored.
- Read issue:
  - A read is issued in ISSUE when credits < FIFO_DEPTH, where credits = pipeline-valid count + FIFO occupancy.
  - acc_addr_o = (base + issued_count) mod 128; the address wraps 127 to 0.
  - acc_rd_en_o is high only in issue cycles.
- Pipeline:
  - S1 registers acc_data_i and the row index.
  - S2: x' = (relu_en and x<0) ? 0 : x; p = x' * {0,scale}, signed 49-bit.
  - S3: if shift>0, r = (p + 2^(shift-1)) >>> shift; if shift=0, r = p. Then saturate to [-128,127] and push to the FIFO.
- Latency: read in cycle t gives out_valid_o in cycle t+3 when the FIFO is empty.
- Throughput: 1 row/cycle with out_ready_i held high.
- Stream rules:
  - Transfer occurs when out_valid_o and out_ready_i are both high.
  - Once valid is asserted, out_data_o and out_row_o are held stable until the transfer.
  - The FIFO never overflows: credits guarantee a free slot.
  - FIFO simultaneous push and pop at full or empty is legal.
  - The FIFO output is registered; empty means out_valid_o=0.
- Rows are emitted strictly in order, 0..num_rows-1.

Optional Feature:
- Macro ACT_ZERO_POINT_EN.
- Defined:
  - Adds input port zero_point_i (in, 8, signed), latched at start.
  - The zero point is added to r after the shift and before saturation; sum width is 50 bits.
- Undefined:
  - The port is absent and the zero point is treated as 0.
  - Results are identical to the defined build with zero_point_i=0.

Test Plan:
- Basic latency and quantization: base=5, num_rows=1, scale=1, shift=0, relu off; row values {0,1,-1,127,128,-129,...} -> one acc read at addr 5; output 3 cycles later as {0,1,-1,127,127,-128,...}; done_o pulses after the handshake.
- ReLU and rounding: relu on, scale=3, shift=2; inputs {-7,5,6,2} -> {0,4,5,2}. Check: 15+2=17>>2=4; 18+2=20>>2=5; 6+2=8>>2=2.
- Wrap and throughput: base=126, num_rows=4, ready held 1 -> reads at 126,127,0,1 on consecutive cycles; out_row_o 0..3 on consecutive cycles.
- Backpressure: num_rows=10, ready=0 for 20 cycles -> exactly FIFO_DEPTH=4 reads issued, then acc_rd_en_o=0; release ready -> 10 rows in order, none lost or duplicated.
- Zero rows and ignored start: num_rows=0 -> no reads, done_o 1 cycle after start. Pulse start_i while busy -> no effect.
- Reset mid-drain: assert rst_i after 3 of 8 rows -> outputs 0 immediately, FSM in IDLE, no done pulse; a new start afterwards works normally.

Source files
------------

// File: rtl/acc_activation_drain.sv
// acc_activation_drain
// Drains result rows from the accumulator store, applies optional ReLU, then
// scale / rounding shift / int8 saturation per element, and streams packed
// rows out through a small credit-gated output FIFO.
// Optional build macro ACT_ZERO_POINT_EN adds a signed zero-point input that is
// added after the rounding shift and before saturation.
module acc_activation_drain #(
    parameter int N_COLS     = 32,
    parameter int ACC_W      = 32,
    parameter int OUT_W      = 8,
    parameter int ADDR_W     = 7,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [ADDR_W-1:0]       base_addr_i,
    input  logic [ADDR_W:0]         num_rows_i,
    input  logic                    relu_en_i,
    input  logic [15:0]             scale_i,
    input  logic [4:0]              shift_i,
`ifdef ACT_ZERO_POINT_EN
    input  logic [7:0]              zero_point_i,
`endif
    output logic                    acc_rd_en_o,
    output logic [ADDR_W-1:0]       acc_addr_o,
    input  logic [N_COLS*ACC_W-1:0] acc_data_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [N_COLS*OUT_W-1:0] out_data_o,
    output logic [ADDR_W-1:0]       out_row_o,
    output logic                    busy_o,
    output logic                    done_o
);
    localparam int PROD_W = ACC_W + 17;
    localparam int SUM_W  = PROD_W + 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(2**(OUT_W-1) - 1);
    localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-(2**(OUT_W-1)));

    // ReLU then multiply by the unsigned scale (zero-extended so the product stays signed)
    function automatic logic signed [PROD_W-1:0] relu_scale(
        input logic signed [ACC_W-1:0] x, input logic relu, input logic [15:0] scale);
        logic signed [ACC_W-1:0] xr;
        xr = (relu && x < 0) ? '0 : x;
        return PROD_W'(xr) * PROD_W'($signed({1'b0, scale}));
    endfunction

    // Round-half-up arithmetic right shift; shift of zero passes through untouched
    function automatic logic signed [PROD_W-1:0] round_shift(
        input logic signed [PROD_W-1:0] p, input logic [4:0] sh);
        logic signed [PROD_W-1:0] half;
        logic signed [PROD_W-1:0] res;
        if (sh == 5'd0) begin
            res = p;
        end else begin
            half = PROD_W'(1) << (sh - 5'd1);
            res  = (p + half) >>> sh;
        end
        return res;
    endfunction

    // Clamp to the signed output range
    function automatic logic [OUT_W-1:0] saturate(input logic signed [SUM_W-1:0] v);
        logic [OUT_W-1:0] res;
        if (v > SAT_MAX)      res = SAT_MAX[OUT_W-1:0];
        else if (v < SAT_MIN) res = SAT_MIN[OUT_W-1:0];
        else                  res = v[OUT_W-1:0];
        return res;
    endfunction

    typedef enum logic [1:0] {IDLE, ISSUE, FLUSH, DONE} state_t;
    state_t state, state_nxt;

    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   rows_q;
    logic [ADDR_W:0]   issued_q;
    logic              relu_q;
    logic [15:0]       scale_q;
    logic [4:0]        shift_q;
    logic [7:0]        zp_q;

    logic              issue;
    logic [CNT_W:0]    credits;
    logic              credit_ok;

    logic                           vld_p1, vld_p2;
    logic [N_COLS*ACC_W-1:0]        data_p1;
    logic [ADDR_W-1:0]              row_p1, row_p2;
    logic signed [PROD_W-1:0]       prod_s2 [N_COLS];
    logic signed [PROD_W-1:0]       prod_p2 [N_COLS];
    logic [N_COLS*OUT_W-1:0]        res_s3;

    logic [N_COLS*OUT_W-1:0]        fifo_data [FIFO_DEPTH];
    logic [ADDR_W-1:0]              fifo_row  [FIFO_DEPTH];
    logic [PTR_W-1:0]               wr_ptr, rd_ptr;
    logic [CNT_W-1:0]               count;
    logic                           push, pop;

    // Every row in flight or parked in the FIFO holds a credit, so the FIFO cannot overflow
    assign credits   = (CNT_W+1)'(vld_p1) + (CNT_W+1)'(vld_p2) + (CNT_W+1)'(count);
    assign credit_ok = credits < (CNT_W+1)'(FIFO_DEPTH);

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic and control outputs
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) state_nxt = (num_rows_i == '0) ? DONE : ISSUE;
            end
            ISSUE: begin
                busy_o = 1'b1;
                issue  = credit_ok;
                if (issue && (issued_q + (ADDR_W+1)'(1) == rows_q)) state_nxt = FLUSH;
            end
            FLUSH: begin
                busy_o = 1'b1;
                if (!vld_p1 && !vld_p2 && count == '0) state_nxt = DONE;
            end
            DONE: begin
                done_o    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign acc_rd_en_o = issue;
    assign acc_addr_o  = issue ? (base_q + issued_q[ADDR_W-1:0]) : '0;

    // Latch drain operands at start and count issued reads
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            base_q   <= '0;
            rows_q   <= '0;
            issued_q <= '0;
            relu_q   <= 1'b0;
            scale_q  <= '0;
            shift_q  <= '0;
`ifdef ACT_ZERO_POINT_EN
            zp_q     <= '0;
`endif
        end else if (state == IDLE && start_i) begin
            base_q   <= base_addr_i;
            rows_q   <= num_rows_i;
            issued_q <= '0;
            relu_q   <= relu_en_i;
            scale_q  <= scale_i;
            shift_q  <= shift_i;
`ifdef ACT_ZERO_POINT_EN
            zp_q     <= zero_point_i;
`endif
        end else if (issue) begin
            issued_q <= issued_q + (ADDR_W+1)'(1);
        end
    end

`ifndef ACT_ZERO_POINT_EN
    assign zp_q = '0;
`endif

    // Pipeline valids travel alongside the data
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p1 <= issue;
            vld_p2 <= vld_p1;
        end
    end

    // ---- S1: capture accumulator row and its relative index ----
    always_ff @(posedge clk_i) begin
        if (issue) begin
            data_p1 <= acc_data_i;
            row_p1  <= issued_q[ADDR_W-1:0];
        end
    end

    // S2 combinational: ReLU and scale per element
    always_comb begin
        for (int c = 0; c < N_COLS; c++)
            prod_s2[c] = relu_scale($signed(data_p1[c*ACC_W +: ACC_W]), relu_q, scale_q);
    end

    // ---- S2: register scaled products ----
    always_ff @(posedge clk_i) begin
        if (vld_p1) begin
            prod_p2 <= prod_s2;
            row_p2  <= row_p1;
        end
    end

    // S3 combinational: rounding shift, zero point, saturation
    always_comb begin
        res_s3 = '0;
        for (int c = 0; c < N_COLS; c++)
            res_s3[c*OUT_W +: OUT_W] = saturate(SUM_W'(round_shift(prod_p2[c], shift_q))
                                                + SUM_W'($signed(zp_q)));
    end

    // ---- S3: push into the output FIFO ----
    assign push = vld_p2;
    assign pop  = out_valid_o && out_ready_i;

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (!push && pop) count <= count - CNT_W'(1);
        end
    end

    // FIFO storage
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_data[wr_ptr] <= res_s3;
            fifo_row[wr_ptr]  <= row_p2;
        end
    end

    assign out_valid_o = (count != '0);
    assign out_data_o  = out_valid_o ? fifo_data[rd_ptr] : '0;
    assign out_row_o   = out_valid_o ? fifo_row[rd_ptr]  : '0;

endmodule

// File: tb/tb_acc_activation_drain.sv
// Randomised bench for acc_activation_drain with a row-level reference model
// and a scoreboard of expected output rows, plus directed literal checks.
`timescale 1ns/1ps
module tb_acc_activation_drain;
    localparam int N_COLS = 32;
    localparam int ACC_W  = 32;
    localparam int OUT_W  = 8;
    localparam int ADDR_W = 7;
    localparam int DEPTH  = 4;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    start = 1'b0;
    logic [ADDR_W-1:0]       base_addr = '0;
    logic [ADDR_W:0]         num_rows = '0;
    logic                    relu_en = 1'b0;
    logic [15:0]             scale_in = '0;
    logic [4:0]              shift_in = '0;
    logic [7:0]              zp_in = '0;
    logic                    acc_rd_en;
    logic [ADDR_W-1:0]       acc_addr;
    logic [N_COLS*ACC_W-1:0] acc_data;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic [N_COLS*OUT_W-1:0] out_data;
    logic [ADDR_W-1:0]       out_row;
    logic                    busy, done;

    logic [N_COLS*ACC_W-1:0] acc_mem [128];
    assign acc_data = acc_mem[acc_addr];

    acc_activation_drain dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .base_addr_i(base_addr), .num_rows_i(num_rows), .relu_en_i(relu_en),
        .scale_i(scale_in), .shift_i(shift_in),
`ifdef ACT_ZERO_POINT_EN
        .zero_point_i(zp_in),
`endif
        .acc_rd_en_o(acc_rd_en), .acc_addr_o(acc_addr), .acc_data_i(acc_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .out_row_o(out_row), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ready_mode = 0;

    // Model state for the drain in progress
    int base_m = 0, n_m = 0;
    int rd_cnt = 0, acc_cnt = 0, done_cnt = 0, done_ref = 0;
    int first_rd = 0, last_rd = 0, first_out = 0, last_out = 0, done_cyc = 0, start_cyc = 0;
    logic [N_COLS*OUT_W-1:0] exp_data [$];
    int                      exp_row  [$];
    logic [N_COLS*OUT_W-1:0] cap_q    [$];
    bit                      hold_prev = 0;
    logic [N_COLS*OUT_W-1:0] prev_data;
    logic [ADDR_W-1:0]       prev_row;

    function automatic void chk(string name, logic [255:0] act, logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Element requantisation from the arithmetic definition, using 64-bit integers
    function automatic logic [7:0] q8(int x, bit relu, int scale, int sh, int zp);
        longint p, r;
        if (relu && x < 0) x = 0;
        p = longint'(x) * longint'(scale);
        if (sh > 0) r = (p + (longint'(1) << (sh - 1))) >>> sh;
        else        r = p;
        r = r + zp;
        if (r > 127)       r = 127;
        else if (r < -128) r = -128;
        return r[7:0];
    endfunction

    function automatic logic [N_COLS*OUT_W-1:0] quant_row(logic [N_COLS*ACC_W-1:0] row,
                                                          bit relu, int scale, int sh, int zp);
        logic [N_COLS*OUT_W-1:0] res;
        logic [31:0] e;
        res = '0;
        for (int c = 0; c < N_COLS; c++) begin
            e = row[c*ACC_W +: ACC_W];
            res[c*OUT_W +: OUT_W] = q8(int'($signed(e)), relu, scale, sh, zp);
        end
        return res;
    endfunction

    function automatic logic [31:0] rand_elem();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 600)) - 32'd300;
            1:       return $urandom();
            2:       return ($urandom_range(0, 1) == 1) ? 32'h7fffffff : 32'h80000000;
            default: return 32'($urandom_range(0, 40)) - 32'd20;
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Writer readiness pattern: 0 = always ready, 1 = random, 2 = stalled
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 1) == 1);
            default: out_ready = 1'b0;
        endcase
    end

    // Compare process: reads, stream stability, scoreboard and completion
    always @(negedge clk) begin
        if (!rst) begin
            if (acc_rd_en) begin
                chk("rd_addr", 256'(acc_addr), 256'((base_m + rd_cnt) % 128));
                chk("rd_in_range", 256'(rd_cnt < n_m), 256'(1));
                chk("credit_bound", 256'((rd_cnt - acc_cnt) < DEPTH), 256'(1));
                if (rd_cnt == 0) first_rd = cyc;
                last_rd = cyc;
                rd_cnt++;
            end
            if (out_valid) begin
                if (hold_prev) begin
                    chk("hold_data", out_data, prev_data);
                    chk("hold_row", 256'(out_row), 256'(prev_row));
                end
                if (out_ready) begin
                    chk("row_expected", 256'(exp_data.size() > 0), 256'(1));
                    if (exp_data.size() > 0) begin
                        chk("out_data", out_data, exp_data[0]);
                        chk("out_row", 256'(out_row), 256'(exp_row[0]));
                        void'(exp_data.pop_front());
                        void'(exp_row.pop_front());
                    end
                    if (acc_cnt == 0) first_out = cyc;
                    last_out = cyc;
                    acc_cnt++;
                    cap_q.push_back(out_data);
                end
            end
            hold_prev = out_valid && !out_ready;
            prev_data = out_data;
            prev_row  = out_row;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_all_rows", 256'(acc_cnt), 256'(n_m));
                chk("done_busy_low", 256'(busy), 256'(0));
                chk("done_no_pending", 256'(exp_data.size()), 256'(0));
            end
        end else begin
            hold_prev = 0;
        end
    end

    task automatic start_drain(int base, int n, bit relu, int scale, int sh, int zp);
        @(posedge clk); #1;
        base_m = base; n_m = n;
        rd_cnt = 0; acc_cnt = 0;
        exp_data.delete(); exp_row.delete(); cap_q.delete();
        for (int i = 0; i < n; i++) begin
            exp_data.push_back(quant_row(acc_mem[(base + i) % 128], relu, scale, sh, zp));
            exp_row.push_back(i);
        end
        base_addr = base[ADDR_W-1:0];
        num_rows  = n[ADDR_W:0];
        relu_en   = relu;
        scale_in  = scale[15:0];
        shift_in  = sh[4:0];
        zp_in     = zp[7:0];
        start     = 1'b1;
        start_cyc = cyc;
        done_ref  = done_cnt;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic pulse_start_ignored();
        @(posedge clk); #1;
        base_addr = 7'd3; num_rows = 8'd9; relu_en = ~relu_en;
        scale_in = 16'd7; shift_in = 5'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(int budget, string name);
        int k;
        k = 0;
        while (done_cnt == done_ref && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk({name, "_done_once"}, 256'(done_cnt - done_ref), 256'(1));
    endtask

    task automatic check_idle_outputs(string name);
        chk({name, "_rd_en"}, 256'(acc_rd_en), 256'(0));
        chk({name, "_addr"}, 256'(acc_addr), 256'(0));
        chk({name, "_valid"}, 256'(out_valid), 256'(0));
        chk({name, "_data"}, out_data, 256'(0));
        chk({name, "_row"}, 256'(out_row), 256'(0));
        chk({name, "_busy"}, 256'(busy), 256'(0));
        chk({name, "_done"}, 256'(done), 256'(0));
    endtask

    task automatic set_elem(int a, int c, int v);
        acc_mem[a][c*ACC_W +: ACC_W] = v;
    endtask

    initial begin
        logic [N_COLS*OUT_W-1:0] r;
        int zp, n, d, k;

        for (int a = 0; a < 128; a++)
            for (int c = 0; c < N_COLS; c++)
                acc_mem[a][c*ACC_W +: ACC_W] = rand_elem();

        // Model pinned to hand-computed values
        chk("model_sat_hi", 256'(q8(128, 0, 1, 0, 0)), 256'(8'h7f));
        chk("model_sat_lo", 256'(q8(-129, 0, 1, 0, 0)), 256'(8'h80));
        chk("model_round", 256'(q8(6, 1, 3, 2, 0)), 256'(8'h05));
        chk("model_relu", 256'(q8(-7, 1, 3, 2, 0)), 256'(8'h00));

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("post_reset");

        // Basic latency and quantisation
        ready_mode = 0;
        set_elem(5, 0, 0);   set_elem(5, 1, 1);    set_elem(5, 2, -1);
        set_elem(5, 3, 127); set_elem(5, 4, 128);  set_elem(5, 5, -129);
        start_drain(5, 1, 0, 1, 0, 0);
        chk("basic_busy", 256'(busy), 256'(1));
        wait_done(40, "basic");
        chk("basic_reads", 256'(rd_cnt), 256'(1));
        chk("basic_latency", 256'(first_out - first_rd), 256'(3));
        chk("basic_caps", 256'(cap_q.size()), 256'(1));
        r = (cap_q.size() > 0) ? cap_q[0] : '0;
        chk("basic_b0", 256'(r[7:0]), 256'(8'h00));
        chk("basic_b1", 256'(r[15:8]), 256'(8'h01));
        chk("basic_b2", 256'(r[23:16]), 256'(8'hff));
        chk("basic_b3", 256'(r[31:24]), 256'(8'h7f));
        chk("basic_b4", 256'(r[39:32]), 256'(8'h7f));
        chk("basic_b5", 256'(r[47:40]), 256'(8'h80));

        // ReLU and rounding
        for (int c = 0; c < N_COLS; c++) set_elem(20, c, 0);
        set_elem(20, 0, -7); set_elem(20, 1, 5); set_elem(20, 2, 6); set_elem(20, 3, 2);
        start_drain(20, 1, 1, 3, 2, 0);
        wait_done(40, "relu");
        r = (cap_q.size() > 0) ? cap_q[0] : '1;
        chk("relu_b0", 256'(r[7:0]), 256'(8'h00));
        chk("relu_b1", 256'(r[15:8]), 256'(8'h04));
        chk("relu_b2", 256'(r[23:16]), 256'(8'h05));
        chk("relu_b3", 256'(r[31:24]), 256'(8'h02));
        chk("relu_rest", 256'(r[255:32]), 256'(0));

        // Address wrap and full throughput, with an ignored start while busy
        start_drain(126, 4, 0, 300, 4, 0);
        pulse_start_ignored();
        wait_done(60, "wrap");
        chk("wrap_rd_span", 256'(last_rd - first_rd), 256'(3));
        chk("wrap_out_span", 256'(last_out - first_out), 256'(3));
        chk("wrap_latency", 256'(first_out - first_rd), 256'(3));

        // Backpressure: credits stop issue at FIFO depth
        ready_mode = 2;
        start_drain(40, 10, 1, 1000, 7, 0);
        repeat (20) @(posedge clk);
        #1;
        chk("bp_reads", 256'(rd_cnt), 256'(DEPTH));
        chk("bp_rd_en_low", 256'(acc_rd_en), 256'(0));
        chk("bp_valid", 256'(out_valid), 256'(1));
        ready_mode = 0;
        wait_done(100, "bp");
        chk("bp_rows", 256'(acc_cnt), 256'(10));

        // Zero rows
        start_drain(10, 0, 0, 1, 0, 0);
        wait_done(10, "zero");
        chk("zero_done_lat", 256'(done_cyc - start_cyc), 256'(1));
        chk("zero_reads", 256'(rd_cnt), 256'(0));

        // Reset mid-drain
        ready_mode = 0;
        start_drain(60, 8, 0, 2, 1, 0);
        k = 0;
        while (acc_cnt < 3 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk("mid_progress", 256'(acc_cnt >= 3), 256'(1));
        d = done_cnt;
        rst = 1'b1;
        #1;
        check_idle_outputs("mid_reset");
        exp_data.delete(); exp_row.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_no_done", 256'(done_cnt), 256'(d));
        check_idle_outputs("mid_idle");
        start_drain(50, 5, 1, 77, 3, 0);
        wait_done(60, "after_reset");

        // Randomised drains with random writer readiness
        for (int t = 0; t < 6; t++) begin
            for (int a = 0; a < 128; a += 3)
                for (int c = 0; c < N_COLS; c++)
                    acc_mem[a][c*ACC_W +: ACC_W] = rand_elem();
            ready_mode = 1;
`ifdef ACT_ZERO_POINT_EN
            zp = int'($urandom_range(0, 255)) - 128;
`else
            zp = 0;
`endif
            n = int'($urandom_range(1, 40));
            start_drain(int'($urandom_range(0, 127)), n, ($urandom_range(0, 1) == 1),
                        ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 65535))
                                                    : int'($urandom_range(0, 300)),
                        int'($urandom_range(0, 31)), zp);
            wait_done(n * 20 + 50, "rand");
        end

        // Full 128-row drain
        ready_mode = 1;
        start_drain(int'($urandom_range(0, 127)), 128, 0, 5, 2, 0);
        wait_done(128 * 20 + 50, "full");
        chk("full_rows", 256'(acc_cnt), 256'(128));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL global_timeout actual=%0d required=finish", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
